radio_rssi_averager: RTL and testbench

- Generates the RSSI ADC sample clock that the radio bridge forwards to the board's RSSI converter.
- Consumes the 10-bit RSSI words the bridge latches on that clock's rising edge.
- Keeps a sliding-window average and a threshold flag for the user PHY (AGC / carrier sense).
- Runs entirely in the radio controller's logic clock domain, which is the domain the bridge uses to latch RSSI data.

---
 rtl/radio_rssi_averager_if.sv | 28 ++
 rtl/radio_rssi_averager.sv | 133 +++++++++++++
 tb/tb_radio_rssi_averager.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/radio_rssi_averager_if.sv
// Signal bundle between the RSSI averager and the radio bridge / user PHY.
// The master side is the averager; the slave side drives run control, ADC data and threshold.
interface radio_rssi_averager_if #(
  parameter int AVG_LEN_LOG2 = 4
);
  logic                     enable;
  logic                     user_RSSI_ADC_clk;
  logic [9:0]               user_RSSI_ADC_D;
  logic [9:0]               rssi_threshold;
  logic [9:0]               rssi_sample;
  logic                     rssi_sample_valid;
  logic [10+AVG_LEN_LOG2-1:0] rssi_sum;
  logic [9:0]               rssi_avg;
  logic                     rssi_avg_valid;
  logic                     rssi_above_thresh;

  modport master (
    input  enable, user_RSSI_ADC_D, rssi_threshold,
    output user_RSSI_ADC_clk, rssi_sample, rssi_sample_valid,
           rssi_sum, rssi_avg, rssi_avg_valid, rssi_above_thresh
  );

  modport slave (
    output enable, user_RSSI_ADC_D, rssi_threshold,
    input  user_RSSI_ADC_clk, rssi_sample, rssi_sample_valid,
           rssi_sum, rssi_avg, rssi_avg_valid, rssi_above_thresh
  );
endinterface

// File: rtl/radio_rssi_averager.sv
// RSSI ADC clock generator, sample capture and sliding-window average with threshold flag.
//   state   | meaning
//   ST_IDLE | disabled: divider parked, window empty
//   ST_RUN  | divider running, one capture per RSSI clock period
module radio_rssi_averager #(
  parameter int CLK_DIV      = 8,
  parameter int AVG_LEN_LOG2 = 4
) (
  input  logic                 controller_logic_clk,
  input  logic                 reset,
  radio_rssi_averager_if.master bus
);
  localparam int DEPTH  = 1 << AVG_LEN_LOG2;
  localparam int SUM_W  = 10 + AVG_LEN_LOG2;
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int FILL_W = AVG_LEN_LOG2 + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FALL  = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_CAP   = CNT_W'(1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             state, state_nxt;
  logic               start;
  logic               capture;
  logic [CNT_W-1:0]   cnt;
  logic               adc_clk;
  logic [9:0]         sample;
  logic               sample_valid;
  logic               sum_upd;
  logic [9:0]         win [DEPTH];
  logic [FILL_W-1:0]  fill;
  logic [SUM_W-1:0]   sum;
  logic               avg_valid;
  logic               above;
  logic [9:0]         avg;

  always_ff @(posedge controller_logic_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.enable) begin
          state_nxt = ST_RUN;
          start     = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.enable) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bridge latches one edge after the rising clock; we take it one edge later (cnt 1->2)
  assign capture = (state == ST_RUN) && bus.enable && (cnt == CNT_CAP);

  always_ff @(posedge controller_logic_clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      adc_clk <= 1'b0;
    end else if (!bus.enable) begin
      cnt     <= '0;
      adc_clk <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      adc_clk <= 1'b1;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      adc_clk <= 1'b1;
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_FALL) adc_clk <= 1'b0;
    end
  end

  always_ff @(posedge controller_logic_clk or posedge reset) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= capture;
      if (capture) sample <= bus.user_RSSI_ADC_D;
    end
  end

  assign avg = sum[SUM_W-1:AVG_LEN_LOG2];

  // Cleared window entries read as 0, so the sum is correct while the window is still filling
  always_ff @(posedge controller_logic_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      fill      <= '0;
      sum       <= '0;
      avg_valid <= 1'b0;
      sum_upd   <= 1'b0;
      above     <= 1'b0;
    end else if (!bus.enable) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      fill      <= '0;
      sum       <= '0;
      avg_valid <= 1'b0;
      sum_upd   <= 1'b0;
      above     <= 1'b0;
    end else begin
      sum_upd <= sample_valid;
      if (sample_valid) begin
        win[0] <= sample;
        for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
        sum <= sum + SUM_W'(sample) - SUM_W'(win[DEPTH-1]);
        if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
        if (fill >= FILL_LAST) avg_valid <= 1'b1;
      end
      if (sum_upd) above <= avg_valid && (avg >= bus.rssi_threshold);
    end
  end

  assign bus.user_RSSI_ADC_clk = adc_clk;
  assign bus.rssi_sample       = sample;
  assign bus.rssi_sample_valid = sample_valid;
  assign bus.rssi_sum          = sum;
  assign bus.rssi_avg          = avg;
  assign bus.rssi_avg_valid    = avg_valid;
  assign bus.rssi_above_thresh = above;
endmodule

// File: tb/tb_radio_rssi_averager.sv
// Randomized bench for radio_rssi_averager against a cycle-indexed reference model
// that keeps the captured history in a queue and sums the window directly.
module tb_radio_rssi_averager;
  localparam int CLK_DIV = 8;
  localparam int N       = 4;
  localparam int DEPTH   = 1 << N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  radio_rssi_averager_if #(.AVG_LEN_LOG2(N)) bus ();

  radio_rssi_averager #(.CLK_DIV(CLK_DIV), .AVG_LEN_LOG2(N)) dut (
    .controller_logic_clk(clk),
    .reset(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // stimulus currently driven
  logic en_v = 1'b0;
  int   d_v = 0;
  int   thr_v = 0;
  bit   d_mode = 1'b0;
  int   d_const = 0;

  // reference model
  int   t;
  bit   m_clk, m_sv, m_avgv, m_above, m_upd;
  int   m_sample, m_sum, n_cap;
  int   hist[$];

  task automatic check_val(string tag, int unsigned obs, int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int window_sum();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s;
  endfunction

  task automatic model_reset();
    t = -1; m_clk = 0; m_sv = 0; m_avgv = 0; m_above = 0; m_upd = 0;
    m_sample = 0; m_sum = 0; n_cap = 0;
    hist.delete();
  endtask

  task automatic model_clear();
    t = -1; m_clk = 0; m_sv = 0; m_avgv = 0; m_above = 0; m_upd = 0;
    m_sum = 0; n_cap = 0;
    hist.delete();
  endtask

  task automatic model_edge();
    if (rst) model_reset();
    else if (!en_v) model_clear();
    else begin
      if (m_upd) m_above = m_avgv && ((m_sum >> N) >= thr_v);
      m_upd = 0;
      if (m_sv) begin
        hist.push_back(m_sample);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        n_cap++;
        m_sum  = window_sum();
        m_avgv = (n_cap >= DEPTH);
        m_upd  = 1;
      end
      t++;
      m_clk = ((t % CLK_DIV) < CLK_DIV / 2);
      m_sv  = ((t % CLK_DIV) == 2);
      if (m_sv) m_sample = d_v;
    end
  endtask

  task automatic check_all();
    check_val("adc_clk",   bus.user_RSSI_ADC_clk, m_clk);
    check_val("sample_vld", bus.rssi_sample_valid, m_sv);
    check_val("sample",    bus.rssi_sample, m_sample);
    check_val("sum",       bus.rssi_sum, m_sum);
    check_val("avg",       bus.rssi_avg, m_sum >> N);
    check_val("avg_valid", bus.rssi_avg_valid, m_avgv);
    check_val("above",     bus.rssi_above_thresh, m_above);
  endtask

  task automatic cycle();
    bus.enable          = en_v;
    bus.user_RSSI_ADC_D = 10'(d_v);
    bus.rssi_threshold  = 10'(thr_v);
    @(posedge clk);
    #1;
    model_edge();
    check_all();
    d_v = d_mode ? d_const : int'($urandom_range(0, 1023));
  endtask

  // disable for one cycle, then enable so the window starts empty
  task automatic restart();
    en_v = 1'b0;
    cycle();
    en_v = 1'b1;
  endtask

  initial begin
    model_reset();
    bus.enable = 1'b0;
    bus.user_RSSI_ADC_D = '0;
    bus.rssi_threshold = '0;
    @(posedge clk);
    #1;
    model_edge();
    check_all();
    rst = 1'b0;

    // random data, random threshold
    thr_v = int'($urandom_range(0, 1023));
    en_v = 1'b1;
    repeat (300) cycle();

    // constant 0x200 fills to sum 0x2000
    d_mode = 1'b1; d_const = 'h200; d_v = d_const;
    restart();
    repeat (130) cycle();
    check_val("const_sum", bus.rssi_sum, 'h2000);
    check_val("const_avg", bus.rssi_avg, 'h200);
    check_val("const_vld", bus.rssi_avg_valid, 1);

    // full-scale then zero
    d_const = 1023; d_v = d_const;
    restart();
    repeat (130) cycle();
    check_val("peak_sum", bus.rssi_sum, 16368);
    check_val("peak_avg", bus.rssi_avg, 1023);
    d_const = 0; d_v = 0;
    repeat (128) cycle();
    check_val("drain_sum", bus.rssi_sum, 0);

    // step 100 -> 300 against threshold 200
    thr_v = 200; d_const = 100; d_v = 100;
    restart();
    repeat (130) cycle();
    check_val("step_low", bus.rssi_above_thresh, 0);
    d_const = 300;
    repeat (140) cycle();
    check_val("step_high", bus.rssi_above_thresh, 1);

    // enable drop after 5 captures, then re-raise
    d_mode = 1'b0;
    restart();
    repeat (36) cycle();
    en_v = 1'b0;
    cycle();
    check_val("drop_clk", bus.user_RSSI_ADC_clk, 0);
    check_val("drop_sum", bus.rssi_sum, 0);
    en_v = 1'b1;
    repeat (130) cycle();

    // enable dropped exactly in a capture cycle
    restart();
    repeat (3) cycle();
    en_v = 1'b0;
    cycle();
    en_v = 1'b1;
    repeat (60) cycle();

    // random enable and threshold activity
    repeat (1500) begin
      if ($urandom_range(0, 99) == 0) en_v = ~en_v;
      if ($urandom_range(0, 49) == 0) thr_v = int'($urandom_range(0, 1023));
      cycle();
    end

    // async reset asserted mid-cycle right after a capture strobe
    restart();
    repeat (20) cycle();
    repeat (CLK_DIV) begin
      if (!m_sv) cycle();
    end
    check_val("pre_rst_sv", bus.rssi_sample_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_val("rst_async_sv",  bus.rssi_sample_valid, 0);
    check_val("rst_async_smp", bus.rssi_sample, 0);
    check_val("rst_async_sum", bus.rssi_sum, 0);
    check_val("rst_async_clk", bus.user_RSSI_ADC_clk, 0);
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    repeat (150) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
